// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and helpers for the multi-port register file
package regfile_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int NREG       = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [NREG-1:0]       busy_vec_t;
    typedef logic [ADDR_WIDTH:0]   busy_cnt_t;

    // Number of busy registers; x0 can never be busy so the result stays below NREG.
    function automatic busy_cnt_t popcount(input busy_vec_t v);
        busy_cnt_t c;
        c = '0;
        for (int k = 0; k < NREG; k++) begin
            c = c + busy_cnt_t'(v[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits, issue gating and busy count (REGFILE_BYPASS_EN)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  i_raddr,
    output logic [NUM_READ-1:0]             o_rbusy,
    input  logic [NUM_WRITE-1:0]            i_wen,
    input  logic [NUM_WRITE-1:0]            i_wclr,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] i_waddr,
    input  logic                            i_issue_valid,
    input  logic [ADDR_WIDTH-1:0]           i_issue_rd,
    output logic                            o_issue_ready,
    output logic [ADDR_WIDTH:0]             o_busy_cnt
);

    busy_vec_t r_busy;
    busy_cnt_t r_busy_cnt;
    busy_vec_t w_clr;
    busy_vec_t w_set;
    busy_vec_t w_view;
    busy_vec_t w_busy_next;

    // Collect this cycle's retirements; writes to x0 never touch the scoreboard.
    always_comb begin
        w_clr = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (i_wen[j] && i_wclr[j]) begin
                w_clr[i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        w_clr[0] = 1'b0;
    end

`ifdef REGFILE_BYPASS_EN
    assign w_view = r_busy & ~w_clr;
`else
    assign w_view = r_busy;
`endif

    assign o_issue_ready = (i_issue_rd == '0) | ~w_view[i_issue_rd];

    // Reserve the issued destination; applied after clears so a new producer wins.
    always_comb begin
        w_set = '0;
        if (i_issue_valid && o_issue_ready && (i_issue_rd != '0)) begin
            w_set[i_issue_rd] = 1'b1;
        end
    end

    assign w_busy_next = (r_busy & ~w_clr) | w_set;

    // Busy vector and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= popcount(w_busy_next);
        end
    end

    assign o_busy_cnt = r_busy_cnt;

    // Per-read-port busy lookup; bit 0 of the view is never set, so x0 reads as not busy.
    always_comb begin
        o_rbusy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            o_rbusy[i] = w_view[i_raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write scoreboard; optional bypass via REGFILE_BYPASS_EN
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  i_raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  o_rdata,
    output logic [NUM_READ-1:0]             o_rbusy,
    input  logic [NUM_WRITE-1:0]            i_wen,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] i_waddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] i_wdata,
    input  logic [NUM_WRITE-1:0]            i_wclr,
    input  logic                            i_issue_valid,
    input  logic [ADDR_WIDTH-1:0]           i_issue_rd,
    output logic                            o_issue_ready,
    output logic [ADDR_WIDTH:0]             o_busy_cnt
);

    reg_data_t r_regs [NREG];
    reg_idx_t  w_ra;
    reg_data_t w_rd;

    // Storage; later write ports are younger, so their assignment lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (i_wen[j] && (i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    r_regs[i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Zero-latency read muxes, optionally forwarding same-cycle write data.
    always_comb begin
        o_rdata = '0;
        w_ra    = '0;
        w_rd    = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_ra = i_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_rd = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (i_wen[j] && (i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)) begin
                    w_rd = i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
            if (w_ra == '0) begin
                w_rd = '0;
            end
            o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        end
    end

    regfile_scoreboard #(
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_raddr       (i_raddr),
        .o_rbusy       (o_rbusy),
        .i_wen         (i_wen),
        .i_wclr        (i_wclr),
        .i_waddr       (i_waddr),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_ready (o_issue_ready),
        .o_busy_cnt    (o_busy_cnt)
    );

endmodule
